// File: rtl/pulse_scheduler.sv
// Four-phase programmable pulse sequencer driven by one shared down-counter.
// Each phase holds its level for period+1 cycles; the sequence runs once or loops.
module pulse_scheduler #(
  parameter int                 CNT_W          = 26,
  parameter logic [CNT_W-1:0]   DEFAULT_PERIOD = CNT_W'(26'h3938700)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic             wr_level,
  input  logic [1:0]       num_phases,
  input  logic             repeat_en,
  input  logic             start,
  input  logic             stop,
  output logic             out_pin,
  output logic             busy,
  output logic [1:0]       phase,
  output logic             done,
  output logic [4:0]       counter_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [1:0]       phase_reg, phase_next;
  logic             out_reg, out_next;
  logic             done_reg, done_next;
  logic [1:0]       num_phases_reg, num_phases_next;
  logic             repeat_reg, repeat_next;

  logic [CNT_W-1:0] period_reg [4];
  logic             level_reg  [4];

  // Phase table: loads below read these registers before this edge's write lands.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_table
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          period_reg[gi] <= DEFAULT_PERIOD;
          level_reg[gi]  <= 1'(gi % 2);
        end else if (wr_en && (wr_addr == 2'(gi))) begin
          period_reg[gi] <= wr_period;
          level_reg[gi]  <= wr_level;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      counter_reg    <= '0;
      phase_reg      <= 2'd0;
      out_reg        <= 1'b0;
      done_reg       <= 1'b0;
      num_phases_reg <= 2'd0;
      repeat_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      counter_reg    <= counter_next;
      phase_reg      <= phase_next;
      out_reg        <= out_next;
      done_reg       <= done_next;
      num_phases_reg <= num_phases_next;
      repeat_reg     <= repeat_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    counter_next    = counter_reg;
    phase_next      = phase_reg;
    out_next        = out_reg;
    done_next       = 1'b0;
    num_phases_next = num_phases_reg;
    repeat_next     = repeat_reg;

    case (state_reg)
      IDLE: begin
        // stop has priority over a simultaneous start
        if (start && !stop) begin
          state_next      = RUN;
          phase_next      = 2'd0;
          counter_next    = period_reg[0];
          out_next        = level_reg[0];
          num_phases_next = num_phases;
          repeat_next     = repeat_en;
        end
      end
      RUN: begin
        if (stop) begin
          state_next   = IDLE;
          phase_next   = 2'd0;
          counter_next = '0;
          out_next     = 1'b0;
        end else if (counter_reg != '0) begin
          counter_next = counter_reg - CNT_W'(1);
        end else if (phase_reg != num_phases_reg) begin
          phase_next   = phase_reg + 2'd1;
          counter_next = period_reg[phase_reg + 2'd1];
          out_next     = level_reg[phase_reg + 2'd1];
        end else if (repeat_reg) begin
          phase_next   = 2'd0;
          counter_next = period_reg[0];
          out_next     = level_reg[0];
        end else begin
          state_next = IDLE;
          phase_next = 2'd0;
          out_next   = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_pin     = out_reg;
  assign busy        = (state_reg == RUN);
  assign phase       = phase_reg;
  assign done        = done_reg;
  assign counter_out = counter_reg[CNT_W-1 -: 5];

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: an occupancy-based model checked every cycle,
// plus literal waveform expectations for the key scenarios.
module tb_pulse_scheduler;
  localparam int CNT_W = 26;
  localparam logic [CNT_W-1:0] DEF = 26'h3938700;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [CNT_W-1:0] wr_period;
  logic             wr_level;
  logic [1:0]       num_phases;
  logic             repeat_en;
  logic             start;
  logic             stop;
  logic             out_pin;
  logic             busy;
  logic [1:0]       phase;
  logic             done;
  logic [4:0]       counter_out;

  int tests = 0;
  int fails = 0;

  pulse_scheduler dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_period(wr_period), .wr_level(wr_level), .num_phases(num_phases),
    .repeat_en(repeat_en), .start(start), .stop(stop), .out_pin(out_pin),
    .busy(busy), .phase(phase), .done(done), .counter_out(counter_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model tracks cycles left in the current phase (period+1), not a counter value.
  logic             m_busy, m_out, m_done, m_rep;
  logic [1:0]       m_ph, m_np;
  logic [CNT_W:0]   m_left;
  logic [CNT_W-1:0] m_per [4];
  logic             m_lvl [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_out <= 1'b0; m_done <= 1'b0; m_rep <= 1'b0;
      m_ph <= 2'd0; m_np <= 2'd0; m_left <= '0;
      for (int i = 0; i < 4; i++) begin
        m_per[i] <= DEF;
        m_lvl[i] <= 1'(i % 2);
      end
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy <= 1'b1; m_ph <= 2'd0; m_out <= m_lvl[0];
          m_left <= {1'b0, m_per[0]} + 1;
          m_np <= num_phases; m_rep <= repeat_en;
        end
      end else if (stop) begin
        m_busy <= 1'b0; m_ph <= 2'd0; m_out <= 1'b0; m_left <= '0;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (m_ph != m_np) begin
        m_ph <= m_ph + 2'd1; m_out <= m_lvl[m_ph + 2'd1];
        m_left <= {1'b0, m_per[m_ph + 2'd1]} + 1;
      end else if (m_rep) begin
        m_ph <= 2'd0; m_out <= m_lvl[0];
        m_left <= {1'b0, m_per[0]} + 1;
      end else begin
        m_busy <= 1'b0; m_ph <= 2'd0; m_out <= 1'b0; m_done <= 1'b1; m_left <= '0;
      end
      if (wr_en) begin
        m_per[wr_addr] <= wr_period;
        m_lvl[wr_addr] <= wr_level;
      end
    end
  end

  logic [CNT_W-1:0] m_cnt;
  assign m_cnt = m_busy ? CNT_W'(m_left - 1) : '0;

  always @(negedge clk) begin
    tests++;
    if (out_pin !== m_out || busy !== m_busy || phase !== m_ph || done !== m_done ||
        counter_out !== m_cnt[CNT_W-1 -: 5]) begin
      fails++;
      $display("FAIL model_cmp t=%0t: got out=%b busy=%b ph=%0d done=%b cnt=%b expected out=%b busy=%b ph=%0d done=%b cnt=%b",
               $time, out_pin, busy, phase, done, counter_out,
               m_out, m_busy, m_ph, m_done, m_cnt[CNT_W-1 -: 5]);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [CNT_W-1:0] p, input logic l);
    wr_en = 1'b1; wr_addr = a; wr_period = p; wr_level = l;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Samples out_pin once per cycle; optionally pulses start after sample pulse_at.
  task automatic trace(input int n, input int pulse_at, output logic [63:0] tr,
                       output int busy_cnt, output int done_cnt);
    tr = '0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tr = {tr[62:0], out_pin};
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      start = (i == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] tr;
    int bc, dc, c1a, c1b;
    bit found;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_period = '0; wr_level = 1'b0;
    num_phases = 2'd0; repeat_en = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", out_pin, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", counter_out, 0);
    $display("[TB] reset state checked");

    // Start on the very first edge after release, default table
    num_phases = 2'd1; repeat_en = 1'b0; rst_n = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("first_start_busy", busy, 1);
    check("default_cnt_top", counter_out, 5'b11100);
    check("default_lvl0", out_pin, 0);
    repeat (200) @(negedge clk);
    check("default_hold", out_pin, 0);
    do_stop();
    check("stop_idle", busy, 0);
    $display("[TB] default-table start and stop");

    wr(2'd0, 3, 1'b1); wr(2'd1, 1, 1'b0); wr(2'd2, 0, 1'b1); wr(2'd3, 2, 1'b0);

    // One-shot sequence
    num_phases = 2'd3; repeat_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    trace(10, -1, tr, bc, dc);
    check("oneshot_pattern", tr[9:0], 10'b1111001000);
    check("oneshot_busy10", bc, 10);
    check("oneshot_nodone", dc, 0);
    check("oneshot_done", done, 1);
    check("oneshot_idle", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    $display("[TB] one-shot pattern %b", tr[9:0]);

    // start+stop in IDLE stays idle
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    check("startstop_idle", busy, 0);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    $display("[TB] start+stop in idle");

    // Restart pulse and setting changes during RUN are ignored
    num_phases = 2'd3; repeat_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    num_phases = 2'd0; repeat_en = 1'b1;
    trace(10, 4, tr, bc, dc);
    check("restart_ignored", tr[9:0], 10'b1111001000);
    check("latched_done", done, 1);
    @(negedge clk);
    $display("[TB] start during run ignored");

    // Looping sequence then stop
    num_phases = 2'd3; repeat_en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    trace(20, -1, tr, bc, dc);
    check("repeat_pattern", tr[19:0], 20'b11110010001111001000);
    check("repeat_nodone", dc, 0);
    do_stop();
    check("repeat_stop_out", out_pin, 0);
    check("repeat_stop_busy", busy, 0);
    check("repeat_stop_done", done, 0);
    @(negedge clk);
    check("repeat_stop_done2", done, 0);
    $display("[TB] repeat pattern and stop");

    // Write entry 1 on the edge it loads: old period this pass, new next pass
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    c1a = 0; c1b = 0;
    for (int i = 0; i < 24; i++) begin
      if (phase == 2'd1) begin
        if (i < 10) c1a++; else c1b++;
      end
      if (i == 3) begin
        wr_en = 1'b1; wr_addr = 2'd1; wr_period = 5; wr_level = 1'b0;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    check("wr_load_old", c1a, 2);
    check("wr_load_new", c1b, 6);
    do_stop();
    $display("[TB] write-on-load phase1 lengths %0d then %0d", c1a, c1b);

    // Asynchronous reset mid-phase 2
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (phase == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_phase2", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out", out_pin, 0);
    check("async_busy", busy, 0);
    check("async_phase", phase, 0);
    check("async_cnt", counter_out, 0);
    check("async_done", done, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    num_phases = 2'd0; repeat_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restored_p0", counter_out, 5'b11100);
    check("restored_l0", out_pin, 0);
    do_stop();
    wr(2'd0, 0, 1'b0);
    num_phases = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("restored_ph1", phase, 1);
    check("restored_l1", out_pin, 1);
    check("restored_p1", counter_out, 5'b11100);
    do_stop();
    $display("[TB] async reset and table restore");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pulse_scheduler.md
PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 Parameter CNT_W, default 26: width of the shared down-counter and of every period entry.
REQ-002 Parameter DEFAULT_PERIOD, default 26'h3938700: reset value of every period entry.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assertion, active-low.
REQ-005 wr_en  input  1: phase-table write strobe; one entry is written per cycle when high.
REQ-006 wr_addr  input  2: index of the phase-table entry to write.
REQ-007 wr_period  input  CNT_W: period value written with wr_en.
REQ-008 wr_level  input  1: output level written with wr_en.
REQ-009 num_phases  input  2: last phase index used (number of phases = num_phases+1); sampled on accepted start.
REQ-010 repeat_en  input  1: 1 = loop the sequence, 0 = one-shot; sampled on accepted start.
REQ-011 start  input  1: start request, level-sampled each cycle.
REQ-012 stop  input  1: abort request, level-sampled each cycle.
REQ-013 out_pin  output  1: registered output level of the current phase.
REQ-014 busy  output  1: high while state is RUN.
REQ-015 phase  output  2: index of the current phase.
REQ-016 done  output  1: one-cycle pulse on normal one-shot completion.
REQ-017 counter_out  output  5: counter[CNT_W-1:CNT_W-5].

Function
REQ-018 The block SHALL hold a 4-entry phase table {period, level}, one shared CNT_W-bit down-counter and a two-state FSM: IDLE, RUN.
REQ-019 Table writes SHALL occur in any state; a write SHALL update the entry at the edge where wr_en is high.
REQ-020 A load of an entry at the same edge as a write to that entry SHALL use the pre-write value.
REQ-021 IDLE, start=1, stop=0: next edge SHALL set state=RUN, phase=0, counter=period[0], out_pin=level[0], and latch num_phases and repeat_en.
REQ-022 RUN, counter!=0: counter SHALL decrement by 1 per cycle; phase and out_pin hold.
REQ-023 RUN, counter==0, phase<latched num_phases: phase SHALL increment, and counter and out_pin SHALL load from the new entry.
REQ-024 RUN, counter==0, phase==latched num_phases, repeat_en=1: phase SHALL wrap to 0 and entry 0 SHALL load; no done pulse.
REQ-025 RUN, counter==0, phase==latched num_phases, repeat_en=0: state SHALL go to IDLE, out_pin=0, phase=0, and done=1 for exactly the next cycle.
REQ-026 Phase occupancy SHALL be period+1 cycles; period=0 SHALL give a one-cycle phase.
REQ-027 stop=1 in RUN: next edge SHALL force IDLE, out_pin=0, phase=0, counter=0, with no done.
REQ-028 start and stop high together: stop SHALL win; from IDLE the block remains in IDLE.
REQ-029 start while in RUN SHALL be ignored; the sequence and its latched settings are unaffected.
REQ-030 Input changes to num_phases or repeat_en during RUN SHALL have no effect until the next accepted start.
REQ-031 Counter arithmetic SHALL be modulo 2^CNT_W with no underflow, because decrement occurs only when the counter is nonzero.

Reset
REQ-032 rst_n=0 SHALL immediately set state=IDLE, counter=0, phase=0, out_pin=0, busy=0, done=0, latched num_phases=0 and repeat_en=0.
REQ-033 Reset SHALL set table entry i to period=DEFAULT_PERIOD, level=i[0].
REQ-034 Reset asserted mid-RUN SHALL abort the sequence with no done pulse.
REQ-035 Release SHALL be synchronous to clk; the first start is accepted on the first edge after release.

Verification
REQ-036 Reset release, no writes, start with num_phases=1, repeat_en=0 -> out_pin=0 for 60,000,001 cycles, then 1 for 60,000,001 cycles, then done pulse; counter_out=5'b11100 right after the first load.
REQ-037 Table periods {3,1,0,2}, levels {1,0,1,0}, num_phases=3, repeat_en=0, start -> out_pin 1,1,1,1,0,0,1,0,0,0; busy high 10 cycles; done high on cycle 11 only.
REQ-038 Same table, repeat_en=1 -> the 10-cycle pattern repeats with no gap and no done; stop -> out_pin=0 and busy=0 next cycle, with no done.
REQ-039 start and stop high together in IDLE -> busy stays 0; start pulse during RUN -> phase sequence unchanged.
REQ-040 Write entry 1 period=5 on the same edge entry 1 loads (old period 1) -> this pass phase 1 lasts 2 cycles, next pass 6 cycles.
REQ-041 rst_n pulled low mid-phase 2 -> all outputs 0 without a clock edge; table entries are restored to their reset values.
